// File: rtl/sign_extend_if.sv
// rtl/sign_extend_if.sv - operand bus between the immediate source and the extension unit
//
// Purpose: groups the immediate, the extension mode and both extended results.
// Signals:
//   in     IN_W   immediate field (instruction bits [15:0])
//   mode   2      00/11 sign extend, 01 zero extend, 10 load-upper
//   out    OUT_W  combinational extended value
//   out_q  OUT_W  out registered on the rising clock edge
// Modports:
//   master  drives in/mode, observes out/out_q
//   slave   the extension unit itself
interface sign_extend_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic [IN_W-1:0]  in;
    logic [1:0]       mode;
    logic [OUT_W-1:0] out;
    logic [OUT_W-1:0] out_q;

    modport master (
        output in,
        output mode,
        input  out,
        input  out_q
    );

    modport slave (
        input  in,
        input  mode,
        output out,
        output out_q
    );
endinterface

// File: rtl/sign_extend.sv
// rtl/sign_extend.sv - immediate extension unit with combinational and registered outputs
//
// Purpose: widens an IN_W-bit instruction immediate to an OUT_W-bit operand.
// Ports:
//   clk    system clock, used only by the registered copy
//   rst_n  asynchronous active-low reset, clears the registered copy
//   bus    sign_extend_if.slave: in, mode -> out (combinational), out_q (one cycle later)
// Parameters:
//   IN_W   immediate width
//   OUT_W  result width, must exceed IN_W
module sign_extend #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    sign_extend_if.slave bus
);
    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] held_d;
    logic [OUT_W-1:0] held_q;

    // Sign extension is the fallback so the reserved mode 11 behaves like 00.
    always_comb begin
        ext = {{PAD_W{bus.in[IN_W-1]}}, bus.in};
        case (bus.mode)
            2'b01:   ext = {{PAD_W{1'b0}}, bus.in};
            2'b10:   ext = {bus.in, {PAD_W{1'b0}}};
            default: ext = {{PAD_W{bus.in[IN_W-1]}}, bus.in};
        endcase
        held_d = ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= '0;
        end else begin
            held_q <= held_d;
        end
    end

    assign bus.out   = ext;
    assign bus.out_q = held_q;
endmodule

// File: tb/tb_sign_extend.sv
// tb/tb_sign_extend.sv - self-checking bench for sign_extend
module tb_sign_extend;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sign_extend_if #(.IN_W(16), .OUT_W(32)) bus ();

    sign_extend #(.IN_W(16), .OUT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] in;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;

    // Reference formulas written independently of the RTL structure.
    function automatic logic [31:0] model(input logic [15:0] v, input logic [1:0] m);
        logic [31:0] z;
        z = {16'h0000, v};
        if (m == 2'b01) return z;
        if (m == 2'b10) return z << 16;
        if (v[15]) return z | 32'hFFFF_0000;
        return z;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s: scoreboard empty, got %h expected a queued value", name, bus.out_q);
        end else begin
            e = sb_q.pop_front();
            check(name, bus.out_q, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          mism;
        logic [15:0] first_in;
        logic [31:0] first_out;

        vecs.push_back(vec_t'{16'h0000, 2'b00, 32'h0000_0000});
        vecs.push_back(vec_t'{16'h0006, 2'b00, 32'h0000_0006});
        vecs.push_back(vec_t'{16'hFFFF, 2'b00, 32'hFFFF_FFFF});
        vecs.push_back(vec_t'{16'h7FFF, 2'b00, 32'h0000_7FFF});
        vecs.push_back(vec_t'{16'h0000, 2'b00, 32'h0000_0000});
        vecs.push_back(vec_t'{16'h8000, 2'b00, 32'hFFFF_8000});
        vecs.push_back(vec_t'{16'h8000, 2'b01, 32'h0000_8000});
        vecs.push_back(vec_t'{16'h1234, 2'b10, 32'h1234_0000});
        vecs.push_back(vec_t'{16'hFFFE, 2'b11, 32'hFFFF_FFFE});
        vecs.push_back(vec_t'{16'hFFFF, 2'b01, 32'h0000_FFFF});
        vecs.push_back(vec_t'{16'h8001, 2'b10, 32'h8001_0000});
        vecs.push_back(vec_t'{16'h0001, 2'b11, 32'h0000_0001});

        // Reset state: out_q held at zero, out still tracks inputs.
        rst_n    = 1'b0;
        bus.in   = 16'hABCD;
        bus.mode = 2'b00;
        #1;
        check("reset_out_q", bus.out_q, 32'h0000_0000);
        check("reset_out_tracks", bus.out, 32'hFFFF_ABCD);
        @(posedge clk); #1;
        check("reset_out_q_hold", bus.out_q, 32'h0000_0000);

        // First capture happens on the first edge after release.
        @(negedge clk);
        rst_n    = 1'b1;
        bus.in   = 16'h1234;
        bus.mode = 2'b10;
        sb_q.push_back(32'h1234_0000);
        @(posedge clk); #1;
        sb_check("first_capture");

        // Table: drive on negedge, check out and out_q after the next posedge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus.in   = vecs[i].in;
            bus.mode = vecs[i].mode;
            sb_q.push_back(vecs[i].exp);
            @(posedge clk); #1;
            check($sformatf("vec%0d_out", i), bus.out, vecs[i].exp);
            sb_check($sformatf("vec%0d_out_q", i));
        end

        // Reset asserted between edges while out_q holds a nonzero value.
        @(negedge clk);
        bus.in   = 16'hFFFF;
        bus.mode = 2'b00;
        @(posedge clk); #1;
        check("pre_reset_out_q", bus.out_q, 32'hFFFF_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_q", bus.out_q, 32'h0000_0000);
        check("midreset_out", bus.out, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("midreset_hold", bus.out_q, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(32'hFFFF_FFFF);
        @(posedge clk); #1;
        sb_check("post_reset_capture");

        // Exhaustive sweep of the combinational path in every mode.
        for (int m = 0; m < 4; m++) begin
            mism      = 0;
            first_in  = '0;
            first_out = '0;
            for (int v = 0; v < 65536; v++) begin
                bus.in   = 16'(v);
                bus.mode = 2'(m);
                #1;
                if (bus.out !== model(16'(v), 2'(m))) begin
                    if (mism == 0) begin
                        first_in  = 16'(v);
                        first_out = bus.out;
                    end
                    mism++;
                end
            end
            if (mism != 0)
                $display("sweep mode %0d first bad in=%h out=%h", m, first_in, first_out);
            check($sformatf("sweep_mode%0d_mismatches", m), 32'(mism), 32'd0);
        end

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
